// File: rtl/cmp_share_sched.sv
// Round-robin scheduler sharing one registered unsigned magnitude comparator
// among four requesters; results come back as a done pulse tagged with the requester ID.
module cmp_share_sched #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] a_bus,
    input  logic [4*WIDTH-1:0] b_bus,
    output logic [3:0]         gnt,
    output logic               busy,
    output logic               done,
    output logic [1:0]         done_id,
    output logic               res_gt,
    output logic               res_lt,
    output logic               res_eq,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RES  = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        rr_ptr;
    logic [1:0]        id_r;
    logic [1:0]        winner;
    logic [1:0]        idx;
    logic              win_valid;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;

    // Search starts one past the last winner and wraps, so the last winner ranks lowest.
    always_comb begin
        winner    = 2'd0;
        win_valid = 1'b0;
        idx       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!win_valid && req[idx]) begin
                winner    = idx;
                win_valid = 1'b1;
            end
        end
    end

    always_comb begin
        gnt = 4'b0000;
        if (state == IDLE && win_valid) begin
            gnt[winner] = 1'b1;
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= 2'd3;
            id_r    <= 2'd0;
            op_a    <= '0;
            op_b    <= '0;
            done    <= 1'b0;
            done_id <= 2'd0;
            res_gt  <= 1'b0;
            res_lt  <= 1'b0;
            res_eq  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        op_a   <= a_bus[int'(winner)*WIDTH +: WIDTH];
                        op_b   <= b_bus[int'(winner)*WIDTH +: WIDTH];
                        id_r   <= winner;
                        rr_ptr <= winner;
                        state  <= CMP;
                    end
                end
                CMP: begin
                    // Flags and done_id update only here, so they hold until the next compare.
                    res_gt  <= (op_a > op_b);
                    res_lt  <= (op_a < op_b);
                    res_eq  <= (op_a == op_b);
                    done    <= 1'b1;
                    done_id <= id_r;
                    state   <= RES;
                end
                RES: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_share_sched.sv
// Directed bench for cmp_share_sched: drivers push expected grants/results into queues,
// a negedge monitor pops and compares whenever gnt or done is presented.
module tb_cmp_share_sched;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     req = 4'b0000;
    logic [4*W-1:0] a_bus = '0;
    logic [4*W-1:0] b_bus = '0;
    logic [3:0]     gnt;
    logic           busy;
    logic           done;
    logic [1:0]     done_id;
    logic           res_gt;
    logic           res_lt;
    logic           res_eq;
    logic [1:0]     dbg_state;

    cmp_share_sched #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .res_gt    (res_gt),
        .res_lt    (res_lt),
        .res_eq    (res_eq),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int last_g = -1;
    bit strict = 1'b0;

    logic [4:0] exp_q[$];     // {id, gt, lt, eq}
    logic [1:0] exp_g_q[$];   // expected grant order
    logic [1:0] g;
    logic [4:0] e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            last_g = -1;
        end else begin
            if (gnt != 4'b0000) begin
                if (exp_g_q.size() == 0) begin
                    check("unexpected_gnt", {28'd0, gnt}, 32'd0);
                end else begin
                    g = exp_g_q.pop_front();
                    check("gnt_order", {28'd0, gnt}, {28'd0, 4'b0001 << g});
                end
                if (last_g >= 0) begin
                    if (strict) begin
                        check("gnt_spacing", cycle - last_g, 3);
                    end else begin
                        checks++;
                        if (cycle - last_g < 3) begin
                            errors++;
                            $display("FAIL gnt_min_spacing actual=%0d required>=3", cycle - last_g);
                        end
                    end
                end
                last_g = cycle;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_result", {27'd0, done_id, res_gt, res_lt, res_eq}, {27'd0, e});
                    check("done_latency", cycle - last_g, 2);
                end
            end
        end
    end

    // Driver tasks
    task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        a_bus[id*W +: W] = a;
        b_bus[id*W +: W] = b;
    endtask

    task automatic expect_req(input int id, input bit gt, input bit lt, input bit eq);
        exp_g_q.push_back(2'(id));
        exp_q.push_back({2'(id), gt, lt, eq});
    endtask

    task automatic wait_gnt(input int id);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(gnt[id] && !rst) && n < 30);
        if (!(gnt[id] && !rst)) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout requester=%0d actual=none required=grant", id);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit gt, input bit lt, input bit eq);
        set_ops(id, a, b);
        expect_req(id, gt, lt, eq);
        req[id] = 1'b1;
        wait_gnt(id);
        req[id] = 1'b0;
    endtask

    task automatic wait_all_gnts();
        int n;
        n = 0;
        while (exp_g_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_g_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL gnts_timeout actual=%0d pending required=0", exp_g_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d pending required=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_done_id", {30'd0, done_id}, 32'd0);
        check("rst_res", {29'd0, res_gt, res_lt, res_eq}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("rst_gnt", {28'd0, gnt}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single request, then flags hold after done falls
        issue(0, 4'b1000, 4'b1011, 1'b0, 1'b1, 1'b0);
        drain();
        repeat (2) @(negedge clk);
        check("hold_res", {29'd0, res_gt, res_lt, res_eq}, 32'b010);
        check("hold_done_id", {30'd0, done_id}, 32'd0);
        check("hold_done_low", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // Equal and boundary operands on requester 2
        issue(2, 4'b1110, 4'b1110, 1'b0, 1'b0, 1'b1);
        issue(2, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
        issue(2, 4'b0000, 4'b1001, 1'b0, 1'b1, 1'b0);
        drain();

        // Round-robin fairness with all requests held from reset
        rst = 1'b1;
        set_ops(0, 4'd1, 4'd2);
        set_ops(1, 4'd5, 4'd3);
        set_ops(2, 4'd7, 4'd7);
        set_ops(3, 4'd0, 4'd15);
        req = 4'b1111;
        expect_req(0, 1'b0, 1'b1, 1'b0);
        expect_req(1, 1'b1, 1'b0, 1'b0);
        expect_req(2, 1'b0, 1'b0, 1'b1);
        expect_req(3, 1'b0, 1'b1, 1'b0);
        expect_req(0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        strict = 1'b1;
        wait_all_gnts();
        req = 4'b0000;
        drain();
        strict = 1'b0;

        // Operand change after grant has no effect
        issue(1, 4'b1010, 4'b0111, 1'b1, 1'b0, 1'b0);
        a_bus[1*W +: W] = 4'b0000;
        drain();

        // Reset during CMP discards the compare and restores rr_ptr
        set_ops(0, 4'd3, 4'd1);
        exp_g_q.push_back(2'd0);
        req[0] = 1'b1;
        wait_gnt(0);
        req[0] = 1'b0;
        rst = 1'b1;
        req = 4'b1010;
        set_ops(1, 4'd2, 4'd6);
        set_ops(3, 4'd9, 4'd4);
        expect_req(1, 1'b0, 1'b1, 1'b0);
        expect_req(3, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_res", {29'd0, res_gt, res_lt, res_eq}, 32'd0);
        check("midrst_gnt", {28'd0, gnt}, 32'b0010);
        @(posedge clk);
        #1 req[1] = 1'b0;
        wait_gnt(3);
        req[3] = 1'b0;
        drain();

        // Late arrival on requester 3 while requester 0 keeps asking
        set_ops(0, 4'd5, 4'd5);
        set_ops(3, 4'd12, 4'd13);
        expect_req(0, 1'b0, 1'b0, 1'b1);
        expect_req(3, 1'b0, 1'b1, 1'b0);
        expect_req(0, 1'b0, 1'b0, 1'b1);
        req[0] = 1'b1;
        wait_gnt(0);
        req[3] = 1'b1;
        wait_all_gnts();
        req = 4'b0000;
        drain();

        repeat (4) @(posedge clk);
        check("leftover_results", exp_q.size(), 0);
        check("leftover_grants", exp_g_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
